// File: rtl/vx_raster_te_pkg.sv
// rtl/vx_raster_te_pkg.sv - shared widths, stack entry and block types for the raster tile evaluator
package vx_raster_te_pkg;

  localparam int RASTER_DATA_BITS  = 32;
  localparam int RASTER_DIM_BITS   = 16;
  localparam int RASTER_PID_BITS   = 8;
  localparam int RASTER_LEVEL_BITS = 5;

  function automatic int raster_te_stack_size(input int tile_logsize, input int block_logsize);
    return 3 * (tile_logsize - block_logsize) + 1;
  endfunction

  localparam int RASTER_TE_STACK_SIZE = raster_te_stack_size(5, 2);

  // edges[i][0] = a, edges[i][1] = b, edges[i][2] = c
  typedef logic [2:0][2:0][RASTER_DATA_BITS-1:0] raster_edges_t;

  typedef struct packed {
    logic [RASTER_DIM_BITS-1:0]        x;
    logic [RASTER_DIM_BITS-1:0]        y;
    logic [RASTER_LEVEL_BITS-1:0]      level;
    logic [2:0][RASTER_DATA_BITS-1:0]  c;
  } raster_te_entry_t;

  typedef struct packed {
    logic [RASTER_DIM_BITS-1:0] x;
    logic [RASTER_DIM_BITS-1:0] y;
    logic [RASTER_PID_BITS-1:0] pid;
    raster_edges_t              edges;
  } raster_te_block_t;

  typedef enum logic {TE_IDLE, TE_RUN} raster_te_state_t;

endpackage

// File: rtl/vx_raster_te_extents.sv
// rtl/vx_raster_te_extents.sv - worst-case edge growth across a 2^level square region
module vx_raster_te_extents
  import vx_raster_te_pkg::*;
(
  input  logic [RASTER_DATA_BITS-1:0]  a,
  input  logic [RASTER_DATA_BITS-1:0]  b,
  input  logic [RASTER_LEVEL_BITS-1:0] level,
  output logic [RASTER_DATA_BITS-1:0]  ext
);

  logic [RASTER_DATA_BITS-1:0] a_pos, b_pos, s;

  assign a_pos = a[RASTER_DATA_BITS-1] ? '0 : a;
  assign b_pos = b[RASTER_DATA_BITS-1] ? '0 : b;
  assign s     = a_pos + b_pos;
  // s * (2^level - 1) without a multiplier
  assign ext   = (s << level) - s;

endmodule

// File: rtl/vx_raster_te.sv
// rtl/vx_raster_te.sv - tile evaluator, depth-first quadrant split to blocks; option VX_RASTER_TE_PERF_EN
module vx_raster_te
  import vx_raster_te_pkg::*;
#(
  parameter int TILE_LOGSIZE  = 5,
  parameter int BLOCK_LOGSIZE = 2,
  parameter int OUT_QUEUE     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic [RASTER_DIM_BITS-1:0]  xloc_in,
  input  logic [RASTER_DIM_BITS-1:0]  yloc_in,
  input  logic [RASTER_PID_BITS-1:0]  pid_in,
  input  raster_edges_t               edges_in,
  output logic                        ready_in,
  output logic                        valid_out,
  output logic [RASTER_DIM_BITS-1:0]  xloc_out,
  output logic [RASTER_DIM_BITS-1:0]  yloc_out,
  output logic [RASTER_PID_BITS-1:0]  pid_out,
  output raster_edges_t               edges_out,
  input  logic                        ready_out,
  output logic                        busy
`ifdef VX_RASTER_TE_PERF_EN
  ,
  output logic [31:0]                 perf_blocks_out,
  output logic [31:0]                 perf_rejects
`endif
);

  localparam int STACK_SIZE = raster_te_stack_size(TILE_LOGSIZE, BLOCK_LOGSIZE);
  localparam int SP_W  = $clog2(STACK_SIZE + 1);
  localparam int PTR_W = $clog2(OUT_QUEUE);
  localparam int CNT_W = $clog2(OUT_QUEUE + 1);
  localparam int DW    = RASTER_DATA_BITS;

  raster_te_state_t state, state_n;
  raster_te_entry_t stk [STACK_SIZE];
  raster_te_entry_t top, root;
  raster_te_entry_t child [4];
  logic [SP_W-1:0] sp, sp_next, top_idx, push_end;
  logic [SP_W-1:0] pos [4];
  logic [2:0][DW-1:0] a_r, b_r;
  logic [RASTER_PID_BITS-1:0] pid_r;
  logic [RASTER_LEVEL_BITS-1:0] half;
  logic [3:0][2:0][DW-1:0] ext;
  logic [2:0][DW-1:0] ext_root;
  logic [3:0] survive;
  logic fire, root_ok, is_leaf, pop_leaf, pop_split;

  raster_te_block_t fifo [OUT_QUEUE];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic fifo_full, fifo_pop;

  assign top_idx   = sp - SP_W'(1);
  assign top       = stk[top_idx];
  assign half      = top.level - RASTER_LEVEL_BITS'(1);
  assign is_leaf   = (top.level == RASTER_LEVEL_BITS'(BLOCK_LOGSIZE));
  assign ready_in  = (state == TE_IDLE);
  assign fire      = valid_in && ready_in;
  assign fifo_full = (count == CNT_W'(OUT_QUEUE));
  assign pop_leaf  = (state == TE_RUN) && is_leaf && !fifo_full;
  assign pop_split = (state == TE_RUN) && !is_leaf;

  for (genvar i = 0; i < 3; i++) begin : g_root_ext
    vx_raster_te_extents u_ext (
      .a(edges_in[i][0]), .b(edges_in[i][1]),
      .level(RASTER_LEVEL_BITS'(TILE_LOGSIZE)), .ext(ext_root[i])
    );
  end

  for (genvar k = 0; k < 4; k++) begin : g_child
    for (genvar i = 0; i < 3; i++) begin : g_edge
      vx_raster_te_extents u_ext (.a(a_r[i]), .b(b_r[i]), .level(half), .ext(ext[k][i]));
    end
  end

  always_comb begin
    root       = '0;
    root.x     = xloc_in;
    root.y     = yloc_in;
    root.level = RASTER_LEVEL_BITS'(TILE_LOGSIZE);
    root_ok    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      root.c[i] = edges_in[i][2];
      if (DW'(edges_in[i][2] + ext_root[i]) >> (DW - 1) != '0) root_ok = 1'b0;
    end
  end

  // child k has qx = k[0], qy = k[1]; k = 0 is the first in Z-order
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      child[k]       = '0;
      child[k].x     = top.x + (((k & 1) != 0) ? (RASTER_DIM_BITS'(1) << half) : '0);
      child[k].y     = top.y + (((k & 2) != 0) ? (RASTER_DIM_BITS'(1) << half) : '0);
      child[k].level = half;
      survive[k]     = 1'b1;
      for (int i = 0; i < 3; i++) begin
        child[k].c[i] = top.c[i] + (((k & 1) != 0) ? (a_r[i] << half) : '0)
                                 + (((k & 2) != 0) ? (b_r[i] << half) : '0);
        if (DW'(child[k].c[i] + ext[k][i]) >> (DW - 1) != '0) survive[k] = 1'b0;
      end
    end
  end

  // survivors overwrite the popped slot upward, (1,1) deepest so (0,0) ends on top
  always_comb begin
    push_end = top_idx;
    for (int k = 3; k >= 0; k--) begin
      pos[k]   = push_end;
      push_end = push_end + SP_W'(survive[k]);
    end
  end

  always_comb begin
    sp_next = sp;
    if (fire && root_ok) sp_next = SP_W'(1);
    else if (pop_leaf)   sp_next = top_idx;
    else if (pop_split)  sp_next = push_end;
  end

  always_comb begin
    state_n = state;
    case (state)
      TE_IDLE: if (fire && root_ok) state_n = TE_RUN;
      TE_RUN:  if (sp_next == '0) state_n = TE_IDLE;
      default: state_n = TE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= TE_IDLE;
      sp    <= '0;
    end else begin
      state <= state_n;
      sp    <= sp_next;
      if (fire && root_ok) stk[0] <= root;
      if (pop_split) begin
        for (int k = 0; k < 4; k++) begin
          if (survive[k]) stk[pos[k]] <= child[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      for (int i = 0; i < 3; i++) begin
        a_r[i] <= edges_in[i][0];
        b_r[i] <= edges_in[i][1];
      end
      pid_r <= pid_in;
    end
  end

  assign fifo_pop  = valid_out && ready_out;
  assign valid_out = (count != '0);
  assign xloc_out  = fifo[rd_ptr].x;
  assign yloc_out  = fifo[rd_ptr].y;
  assign pid_out   = fifo[rd_ptr].pid;
  assign edges_out = fifo[rd_ptr].edges;
  assign busy      = (sp != '0) || (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_leaf) begin
        fifo[wr_ptr].x   <= top.x;
        fifo[wr_ptr].y   <= top.y;
        fifo[wr_ptr].pid <= pid_r;
        for (int i = 0; i < 3; i++) begin
          fifo[wr_ptr].edges[i] <= {top.c[i], b_r[i], a_r[i]};
        end
        wr_ptr <= (wr_ptr == PTR_W'(OUT_QUEUE - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) rd_ptr <= (rd_ptr == PTR_W'(OUT_QUEUE - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (pop_leaf && !fifo_pop)      count <= count + CNT_W'(1);
      else if (!pop_leaf && fifo_pop) count <= count - CNT_W'(1);
    end
  end

`ifdef VX_RASTER_TE_PERF_EN
  logic [2:0] rejects_now;

  always_comb begin
    rejects_now = '0;
    if (fire && !root_ok) rejects_now = 3'd1;
    else if (pop_split)   rejects_now = 3'd4 - 3'($countones(survive));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_blocks_out <= '0;
      perf_rejects    <= '0;
    end else begin
      perf_blocks_out <= perf_blocks_out + 32'(fifo_pop);
      perf_rejects    <= perf_rejects + 32'(rejects_now);
    end
  end
`endif

endmodule

// File: tb/tb_vx_raster_te.sv
// tb/tb_vx_raster_te.sv - self-checking bench for vx_raster_te with a Morton-order block model
module tb_vx_raster_te;
  import vx_raster_te_pkg::*;

  localparam int TILE  = 5;
  localparam int BLOCK = 2;

  logic clk = 1'b0;
  logic reset, valid_in, ready_in, valid_out, ready_out, busy;
  logic [RASTER_DIM_BITS-1:0] xloc_in, yloc_in, xloc_out, yloc_out;
  logic [RASTER_PID_BITS-1:0] pid_in, pid_out;
  raster_edges_t edges_in, edges_out;
`ifdef VX_RASTER_TE_PERF_EN
  logic [31:0] perf_blocks_out, perf_rejects;
`endif

  always #5 clk = ~clk;

  vx_raster_te #(.TILE_LOGSIZE(TILE), .BLOCK_LOGSIZE(BLOCK), .OUT_QUEUE(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .xloc_in(xloc_in), .yloc_in(yloc_in), .pid_in(pid_in), .edges_in(edges_in),
    .ready_in(ready_in), .valid_out(valid_out),
    .xloc_out(xloc_out), .yloc_out(yloc_out), .pid_out(pid_out), .edges_out(edges_out),
    .ready_out(ready_out), .busy(busy)
`ifdef VX_RASTER_TE_PERF_EN
    , .perf_blocks_out(perf_blocks_out), .perf_rejects(perf_rejects)
`endif
  );

  typedef struct {
    logic [RASTER_DIM_BITS-1:0] x;
    logic [RASTER_DIM_BITS-1:0] y;
    logic [RASTER_PID_BITS-1:0] pid;
    raster_edges_t              edges;
  } blk_t;

  blk_t exp_q[$];
  blk_t model_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int blocks_seen = 0;
  int fire_wait = 0;
  int pending_at_fire = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic raster_edges_t mk_edges(input int a0, input int b0, input int c0);
    raster_edges_t e;
    for (int i = 0; i < 3; i++) begin
      e[i][0] = 32'd0;
      e[i][1] = 32'd0;
      e[i][2] = 32'd1;
    end
    e[0][0] = a0;
    e[0][1] = b0;
    e[0][2] = c0;
    return e;
  endfunction

  // Enumerate blocks in Morton order; a block survives if no enclosing region is rejected.
  task automatic model_tile(input int tx, input int ty, input int pid, input raster_edges_t e);
    int nb, bx, by, dx, dy, rdx, rdy, mask, ai, bi, ci, s, ev, ext;
    bit ok;
    blk_t b;
    model_q.delete();
    nb = TILE - BLOCK;
    for (int m = 0; m < (1 << (2 * nb)); m++) begin
      bx = 0;
      by = 0;
      for (int j = 0; j < nb; j++) begin
        bx = bx | (((m >> (2 * j)) & 1) << j);
        by = by | (((m >> (2 * j + 1)) & 1) << j);
      end
      dx = bx << BLOCK;
      dy = by << BLOCK;
      ok = 1'b1;
      for (int l = TILE; l >= BLOCK; l--) begin
        mask = ~((1 << l) - 1);
        rdx = dx & mask;
        rdy = dy & mask;
        for (int i = 0; i < 3; i++) begin
          ai = e[i][0];
          bi = e[i][1];
          ci = e[i][2];
          s = (ai > 0 ? ai : 0) + (bi > 0 ? bi : 0);
          ev = ci + ai * rdx + bi * rdy;
          ext = s * ((1 << l) - 1);
          if (ev + ext < 0) ok = 1'b0;
        end
      end
      if (ok) begin
        b.x = RASTER_DIM_BITS'(tx + dx);
        b.y = RASTER_DIM_BITS'(ty + dy);
        b.pid = RASTER_PID_BITS'(pid);
        b.edges = e;
        for (int i = 0; i < 3; i++) begin
          ai = e[i][0];
          bi = e[i][1];
          ci = e[i][2];
          b.edges[i][2] = ci + ai * dx + bi * dy;
        end
        model_q.push_back(b);
      end
    end
  endtask

  task automatic send_tile(input int tx, input int ty, input int pid, input raster_edges_t e);
    int n;
    n = 0;
    model_tile(tx, ty, pid, e);
    xloc_in = RASTER_DIM_BITS'(tx);
    yloc_in = RASTER_DIM_BITS'(ty);
    pid_in = RASTER_PID_BITS'(pid);
    edges_in = e;
    valid_in = 1'b1;
    while (!ready_in && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("tile_accept", 64'(ready_in), 64'd1);
    @(posedge clk);
    pending_at_fire = exp_q.size();
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    #1;
    valid_in = 1'b0;
    fire_wait = n;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 64'(exp_q.size() == 0 && !busy), 64'd1);
    chk("ready_after_drain", 64'(ready_in), 64'd1);
  endtask

  task automatic wait_blocks(input int target);
    int n;
    n = 0;
    while (blocks_seen < target && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_blocks", 64'(blocks_seen >= target), 64'd1);
  endtask

  // Output checker: every accepted block against the scoreboard, plus hold-stability under backpressure.
  initial begin
    blk_t e, held;
    bit stall_prev;
    stall_prev = 1'b0;
    held = '{default: '0};
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", 64'(valid_out), 64'd1);
          chk("stall_x", 64'(xloc_out), 64'(held.x));
          chk("stall_y", 64'(yloc_out), 64'(held.y));
          chk("stall_c0", 64'(edges_out[0][2]), 64'(held.edges[0][2]));
        end
        if (valid_out && ready_out) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_block", 64'(xloc_out), 64'hffff_ffff_ffff_ffff);
          end else begin
            e = exp_q.pop_front();
            chk("blk_x", 64'(xloc_out), 64'(e.x));
            chk("blk_y", 64'(yloc_out), 64'(e.y));
            chk("blk_pid", 64'(pid_out), 64'(e.pid));
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                chk($sformatf("blk_edge%0d_%0d", i, j), 64'(edges_out[i][j]), 64'(e.edges[i][j]));
            blocks_seen++;
          end
        end
        stall_prev = valid_out && !ready_out;
        held.x = xloc_out;
        held.y = yloc_out;
        held.edges = edges_out;
      end
    end
  end

  initial begin
    raster_edges_t e_all, e_rej, e_half;
    int b0, lat;
    bit all_low;
    reset = 1'b1;
    valid_in = 1'b0;
    ready_out = 1'b1;
    xloc_in = '0;
    yloc_in = '0;
    pid_in = '0;
    edges_in = '0;
    e_all = mk_edges(0, 0, 1);
    e_rej = mk_edges(0, 0, -1);
    e_half = mk_edges(-1, 0, 15);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_out", 64'(valid_out), 64'd0);
    chk("reset_ready_in", 64'(ready_in), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // T1: full tile
    b0 = blocks_seen;
    send_tile(64, 32, 7, e_all);
    chk("t1_model_count", 64'(model_q.size()), 64'd64);
    chk("t1_m0_x", 64'(model_q[0].x), 64'd64);
    chk("t1_m0_y", 64'(model_q[0].y), 64'd32);
    chk("t1_m1_x", 64'(model_q[1].x), 64'd68);
    chk("t1_m1_y", 64'(model_q[1].y), 64'd32);
    chk("t1_m2_x", 64'(model_q[2].x), 64'd64);
    chk("t1_m2_y", 64'(model_q[2].y), 64'd36);
    chk("t1_m3_x", 64'(model_q[3].x), 64'd68);
    chk("t1_m3_y", 64'(model_q[3].y), 64'd36);
    chk("t1_m5_c0", 64'(model_q[5].edges[0][2]), 64'd1);
    chk("t1_ready_low", 64'(ready_in), 64'd0);
    lat = 0;
    while (!valid_out && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("t1_first_latency", 64'(lat), 64'd4);
    wait_drain();
    chk("t1_blocks", 64'(blocks_seen - b0), 64'd64);

    // T2: root rejected
    b0 = blocks_seen;
    send_tile(0, 0, 3, e_rej);
    chk("t2_model_count", 64'(model_q.size()), 64'd0);
    all_low = 1'b1;
    repeat (6) begin
      if (busy || !ready_in) all_low = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("t2_idle_after_reject", 64'(all_low), 64'd1);
    chk("t2_blocks", 64'(blocks_seen - b0), 64'd0);

    // T3: half plane x < 16
    b0 = blocks_seen;
    send_tile(0, 0, 3, e_half);
    chk("t3_model_count", 64'(model_q.size()), 64'd32);
    all_low = 1'b1;
    foreach (model_q[i]) begin
      if (model_q[i].x >= 16) all_low = 1'b0;
      if (model_q[i].edges[0][2] != 32'(15 - int'(model_q[i].x))) all_low = 1'b0;
    end
    chk("t3_model_x_c0", 64'(all_low), 64'd1);
    wait_drain();
    chk("t3_blocks", 64'(blocks_seen - b0), 64'd32);

    // T4: backpressure after the 5th block
    b0 = blocks_seen;
    send_tile(64, 32, 7, e_all);
    wait_blocks(b0 + 5);
    ready_out = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    ready_out = 1'b1;
    wait_drain();
    chk("t4_blocks", 64'(blocks_seen - b0), 64'd64);

    // T5: reset mid-tile, then T3
    send_tile(64, 32, 7, e_all);
    wait_blocks(blocks_seen + 10);
    ready_out = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ready_out = 1'b1;
    chk("t5_valid_after_reset", 64'(valid_out), 64'd0);
    chk("t5_busy_after_reset", 64'(busy), 64'd0);
    chk("t5_ready_after_reset", 64'(ready_in), 64'd1);
    b0 = blocks_seen;
    send_tile(0, 0, 5, e_half);
    wait_drain();
    chk("t5_blocks", 64'(blocks_seen - b0), 64'd32);

    // T6: two tiles back to back
    b0 = blocks_seen;
    send_tile(128, 64, 1, e_all);
    send_tile(0, 0, 2, e_half);
    chk("t6_b_waited", 64'(fire_wait > 0), 64'd1);
    chk("t6_a_pending_le_buffer", 64'(pending_at_fire <= 4), 64'd1);
    wait_drain();
    chk("t6_blocks", 64'(blocks_seen - b0), 64'd96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
